// File: rtl/lfsr_ctrl.sv
// Round-robin controller sharing one 8-bit LFSR among NREQ requesters: seed load, STEPS shifts per draw, one-cycle grant.
// Optional macro LFSR_CTRL_LOCKUP_EN: an all-zero draw is withheld and retried from SEED for the same winner.
module lfsr_ctrl #(
    parameter int          NREQ  = 4,
    parameter int          STEPS = 8,
    parameter logic [7:0]  SEED  = 8'hE9
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [7:0]      o_rnd_data,
    output logic            o_rnd_valid,
    input  logic            i_reseed,
    input  logic [7:0]      i_seed_in,
    output logic            o_busy,
    output logic [7:0]      o_lfsr_data,
    output logic            o_lfsr_load,
    output logic            o_lfsr_en,
    input  logic [7:0]      i_lfsr_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {LOAD, IDLE, STEP, GRANT} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_cnt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_winner;
    logic [PW-1:0]   w_winner;
    logic [PW-1:0]   w_ptr_next;
    logic            w_found;
    logic            r_pend;
    logic            r_retry;
    logic [7:0]      r_seed;
    logic [7:0]      r_rnd_data;
    logic            w_lockup;
    logic            w_grant;
    logic [NREQ-1:0] w_gnt;
    int              v_idx;

    // Scan downward from ptr+NREQ-1 to ptr so the nearest set bit at or after ptr is the last one written.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            v_idx = (int'(r_ptr) + i) % NREQ;
            if (i_req[PW'(v_idx)]) begin
                w_found  = 1'b1;
                w_winner = PW'(v_idx);
            end
        end
    end

    assign w_ptr_next = (r_winner == PW'(NREQ - 1)) ? '0 : r_winner + PW'(1);

`ifdef LFSR_CTRL_LOCKUP_EN
    assign w_lockup = (r_state == GRANT) && (i_lfsr_out == 8'h00);
`else
    assign w_lockup = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:    w_state_next = r_retry ? STEP : IDLE;
            IDLE: begin
                if (r_pend) begin
                    w_state_next = LOAD;
                end else if (w_found) begin
                    w_state_next = STEP;
                end
            end
            STEP:    if (r_cnt == 8'd1) w_state_next = GRANT;
            GRANT:   w_state_next = w_lockup ? LOAD : IDLE;
            default: w_state_next = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= 8'd0;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_pend     <= 1'b0;
            r_retry    <= 1'b0;
            r_seed     <= SEED;
            r_rnd_data <= 8'h00;
        end else begin
            if (i_reseed) begin
                r_pend <= 1'b1;
                r_seed <= (i_seed_in == 8'h00) ? SEED : i_seed_in;
            end else if (r_state == LOAD) begin
                r_pend <= 1'b0;
            end

            // Counter is preloaded in every non-STEP state so any entry into STEP starts a full run.
            if (r_state == STEP) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                r_cnt <= 8'(STEPS);
            end

            case (r_state)
                LOAD:  r_retry <= 1'b0;
                IDLE:  if (!r_pend && w_found) r_winner <= w_winner;
                GRANT: begin
                    if (w_lockup) begin
                        r_retry <= 1'b1;
                        if (!i_reseed) r_seed <= SEED;
                    end else begin
                        r_rnd_data <= i_lfsr_out;
                        r_ptr      <= w_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_grant = (r_state == GRANT) && !w_lockup;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign w_gnt[gi] = w_grant && (r_winner == PW'(gi));
        end
    endgenerate

    // During the grant cycle the freshly stepped LFSR value is presented directly so data is valid with gnt.
    assign o_gnt       = w_gnt;
    assign o_rnd_valid = w_grant;
    assign o_rnd_data  = w_grant ? i_lfsr_out : r_rnd_data;
    assign o_busy      = (r_state != IDLE);
    assign o_lfsr_load = (r_state == LOAD);
    assign o_lfsr_en   = (r_state == STEP);
    assign o_lfsr_data = r_seed;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl; the bench itself plays the 8-bit LFSR (x^8+x^6+x^5+x^4+1, shift left).
module tb_lfsr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       reseed;
    logic [7:0] seed_in;
    logic       busy;
    logic [7:0] lfsr_data;
    logic       lfsr_load;
    logic       lfsr_en;
    logic [7:0] lfsr_out;
    logic [7:0] m_lfsr;
    logic       force_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lfsr_load) begin
            m_lfsr <= lfsr_data;
        end else if (lfsr_en) begin
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    assign lfsr_out = force_zero ? 8'h00 : m_lfsr;

    lfsr_ctrl #(.NREQ(4), .STEPS(8), .SEED(8'hE9)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .o_gnt       (gnt),
        .o_rnd_data  (rnd_data),
        .o_rnd_valid (rnd_valid),
        .i_reseed    (reseed),
        .i_seed_in   (seed_in),
        .o_busy      (busy),
        .o_lfsr_data (lfsr_data),
        .o_lfsr_load (lfsr_load),
        .o_lfsr_en   (lfsr_en),
        .i_lfsr_out  (lfsr_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"},   32'(gnt), 32'h0);
        check({tag, "_valid"}, 32'(rnd_valid), 32'h0);
        check({tag, "_data"},  32'(rnd_data), 32'h00);
        check({tag, "_en"},    32'(lfsr_en), 32'h0);
        check({tag, "_load"},  32'(lfsr_load), 32'h1);
        check({tag, "_seed"},  32'(lfsr_data), 32'hE9);
        check({tag, "_busy"},  32'(busy), 32'h1);
        $display("reset %s gnt=%b load=%b seed=%h busy=%b", tag, gnt, lfsr_load, lfsr_data, busy);
    endtask

    // One draw: cycles are counted from the current cycle to the grant cycle; exp_data < 0 means "reference LFSR".
    task automatic draw(input string tag, input logic [3:0] rq, input bit hold, input logic [3:0] exp_gnt,
                        input int exp_cyc, input int exp_en, input int exp_data,
                        input int rs_at, input logic [7:0] rs_val, input int fz_at);
        int         cyc    = 0;
        int         en_cnt = 0;
        logic [7:0] want;
        req = rq;
        while (1) begin
            tick;
            cyc++;
            if (lfsr_en) begin
                en_cnt++;
                if (!hold) req = '0;
            end
            if (gnt != 4'b0000 || cyc >= 40) break;
            reseed     = (cyc == rs_at);
            seed_in    = rs_val;
            force_zero = (fz_at != 0) && (cyc == fz_at || cyc == fz_at + 1);
        end
        want = (exp_data < 0) ? m_lfsr : 8'(exp_data);
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_en"},     32'(en_cnt), 32'(exp_en));
        check({tag, "_gnt"},    32'(gnt), 32'(exp_gnt));
        check({tag, "_valid"},  32'(rnd_valid), 32'h1);
        check({tag, "_data"},   32'(rnd_data), 32'(want));
        $display("draw %s gnt=%b data=%h cycles=%0d en=%0d", tag, gnt, rnd_data, cyc, en_cnt);
        reseed     = 1'b0;
        force_zero = 1'b0;
        if (!hold) req = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        reseed     = 1'b0;
        seed_in    = 8'h00;
        force_zero = 1'b0;
        tick;
        tick;
        tick;
        check_reset("rst");

        rst_n = 1'b1;
        check("rel_load", 32'(lfsr_load), 32'h1);
        check("rel_seed", 32'(lfsr_data), 32'hE9);
        tick;
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_gnt",  32'(gnt), 32'h0);
        check("idle_load", 32'(lfsr_load), 32'h0);

        // 8 shifts from E9: D3 A6 4C 99 33 66 CD 9A
        draw("single", 4'b0100, 1'b0, 4'b0100, 9, 8, 32'h9A, 0, 8'h00, 0);
        tick;
        check("post_gnt",   32'(gnt), 32'h0);
        check("post_valid", 32'(rnd_valid), 32'h0);
        check("post_hold",  32'(rnd_data), 32'h9A);
        check("post_busy",  32'(busy), 32'h0);

        // ptr is 3 after granting requester 2
        draw("rr0", 4'b1111, 1'b1, 4'b1000, 9,  8, -1, 0, 8'h00, 0);
        draw("rr1", 4'b1111, 1'b1, 4'b0001, 10, 8, -1, 0, 8'h00, 0);
        draw("rr2", 4'b1111, 1'b1, 4'b0010, 10, 8, -1, 0, 8'h00, 0);
        draw("rr3", 4'b1111, 1'b1, 4'b0100, 10, 8, -1, 0, 8'h00, 0);
        draw("rr4", 4'b1111, 1'b1, 4'b1000, 10, 8, -1, 0, 8'h00, 0);
        req = '0;
        tick;

        draw("rs5a", 4'b0010, 1'b0, 4'b0010, 9, 8, -1, 3, 8'h5A, 0);
        tick;
        check("rs5a_idle", 32'(lfsr_load), 32'h0);
        tick;
        check("rs5a_load", 32'(lfsr_load), 32'h1);
        check("rs5a_seed", 32'(lfsr_data), 32'h5A);
        tick;
        check("rs5a_back", 32'(busy), 32'h0);
        draw("after5a", 4'b0100, 1'b0, 4'b0100, 9, 8, -1, 0, 8'h00, 0);
        tick;

        draw("rs00", 4'b0001, 1'b0, 4'b0001, 9, 8, -1, 2, 8'h00, 0);
        tick;
        tick;
        check("rs00_load", 32'(lfsr_load), 32'h1);
        check("rs00_seed", 32'(lfsr_data), 32'hE9);
        tick;

`ifdef LFSR_CTRL_LOCKUP_EN
        draw("zero", 4'b0010, 1'b0, 4'b0010, 19, 16, 32'h9A, 0, 8'h00, 8);
`else
        draw("zero", 4'b0010, 1'b0, 4'b0010, 9, 8, 32'h00, 0, 8'h00, 8);
`endif
        tick;

        req = 4'b1000;
        tick;
        tick;
        tick;
        tick;
        check("mid_en", 32'(lfsr_en), 32'h1);
        req   = '0;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick;
        tick;
        check_reset("midrst_hold");
        rst_n = 1'b1;
        tick;
        check("midrst_idle", 32'(busy), 32'h0);
        draw("ptr0", 4'b1111, 1'b0, 4'b0001, 9, 8, -1, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
